// File: rtl/bomberman_pkg.sv
// Shared types and constants for the Bomberman tile renderer.
package bomberman_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    BRICK = 2'd2,
    BOMB  = 2'd3
  } tile_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned GRID_W     = 20;
  localparam int unsigned GRID_H     = 15;
  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned MAP_DEPTH  = 300;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned CHAN_W     = 10;
  localparam int unsigned FRAME_W    = 5;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  localparam rgb_t COL_EMPTY     = '{r: 10'h000, g: 10'h200, b: 10'h000};
  localparam rgb_t COL_WALL      = '{r: 10'h1FF, g: 10'h1FF, b: 10'h1FF};
  localparam rgb_t COL_WALL_EDGE = '{r: 10'h0FF, g: 10'h0FF, b: 10'h0FF};
  localparam rgb_t COL_BRICK     = '{r: 10'h2C0, g: 10'h100, b: 10'h000};
  localparam rgb_t COL_BOMB      = '{r: 10'h3FF, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_GRID      = '{r: 10'h080, g: 10'h080, b: 10'h080};
  localparam rgb_t COL_BLACK     = '{r: 10'h000, g: 10'h000, b: 10'h000};

  // Map address row*20+col built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [3:0] row, input logic [4:0] col);
    return ADDR_W'({row, 4'b0000}) + ADDR_W'({row, 2'b00}) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/tile_ram.sv
// 300x2 simple dual-port tile map; a colliding read returns the old entry.
module tile_ram
  import bomberman_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tile_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output tile_t             rdata
);

  tile_t mem [MAP_DEPTH];

  // Write port and registered read port share one clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_renderer.sv
// Pixel colour stage: 3-cycle pipeline from synchro coordinates to the VGA DAC.
// Optional feature: define TILE_GRID_EN to overlay a grey tile grid in RUN.
module tile_renderer
  import bomberman_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               blank_in,
  input  logic               tile_we,
  input  logic [4:0]         tile_col,
  input  logic [3:0]         tile_row,
  input  logic [1:0]         tile_data,
  output logic [CHAN_W-1:0]  vga_r,
  output logic [CHAN_W-1:0]  vga_g,
  output logic [CHAN_W-1:0]  vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank,
  output logic               init_done
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [4:0]        clr_col;
  logic [3:0]        clr_row;
  logic              clr_wall;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  tile_t             ram_wdata;
  tile_t             ram_rdata;

  logic              onscreen;
  logic [ADDR_W-1:0] s1_addr;
  logic [4:0]        s1_x5, s1_y5, s2_x5, s2_y5;
  logic              s1_vis, s2_vis, s1_run, s2_run;
  logic [LATENCY-1:0] hs_sr, vs_sr, blank_sr;
  logic [FRAME_W-1:0] frame_cnt;
  rgb_t              pix_rgb;

  assign clr_wall = (clr_row == 4'd0) || (clr_row == 4'(GRID_H - 1)) ||
                    (clr_col == 5'd0) || (clr_col == 5'(GRID_W - 1)) ||
                    (!clr_row[0] && !clr_col[0]);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nx;
  end

  // Next state and RAM write-port steering (clear sweep vs game writes).
  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = EMPTY;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = clr_wall ? WALL : EMPTY;
        if (clr_addr == ADDR_W'(MAP_DEPTH - 1)) state_nx = ST_RUN;
      end
      ST_RUN: begin
        ram_we    = tile_we && (tile_col < 5'(GRID_W)) && (tile_row < 4'(GRID_H));
        ram_waddr = tile_addr(tile_row, tile_col);
        ram_wdata = tile_t'(tile_data);
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  // Clear sweep counters walk the map in address order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
      clr_col  <= '0;
      clr_row  <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ADDR_W'(1);
      if (clr_col == 5'(GRID_W - 1)) begin
        clr_col <= '0;
        clr_row <= clr_row + 4'd1;
      end else begin
        clr_col <= clr_col + 5'd1;
      end
    end
  end

  // init_done follows RUN by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) init_done <= 1'b0;
    else       init_done <= (state == ST_RUN);
  end

  tile_ram u_tile_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (ram_rdata)
  );

  assign onscreen = (pix_x < COORD_W'(SCREEN_W)) && (pix_y < COORD_W'(SCREEN_H));

  // Stage 1: tile address (clamped off-screen) and intra-tile offsets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_addr <= '0;
      s1_x5   <= '0;
      s1_y5   <= '0;
      s1_vis  <= 1'b0;
      s1_run  <= 1'b0;
    end else begin
      s1_addr <= onscreen ? tile_addr(pix_y[8:TILE_SHIFT], pix_x[9:TILE_SHIFT]) : '0;
      s1_x5   <= pix_x[TILE_SHIFT-1:0];
      s1_y5   <= pix_y[TILE_SHIFT-1:0];
      s1_vis  <= onscreen;
      s1_run  <= (state == ST_RUN);
    end
  end

  // Stage 2: offsets travel alongside the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_x5  <= '0;
      s2_y5  <= '0;
      s2_vis <= 1'b0;
      s2_run <= 1'b0;
    end else begin
      s2_x5  <= s1_x5;
      s2_y5  <= s1_y5;
      s2_vis <= s1_vis;
      s2_run <= s1_run;
    end
  end

  // Sync/blank delay lines matching the colour pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sr    <= '1;
      vs_sr    <= '1;
      blank_sr <= '0;
    end else begin
      hs_sr    <= {hs_sr[LATENCY-2:0], hs_in};
      vs_sr    <= {vs_sr[LATENCY-2:0], vs_in};
      blank_sr <= {blank_sr[LATENCY-2:0], blank_in};
    end
  end

  assign vga_hs    = hs_sr[LATENCY-1];
  assign vga_vs    = vs_sr[LATENCY-1];
  assign vga_blank = blank_sr[LATENCY-1];

  // Frame counter advances on each vs_in falling edge; bit 4 blinks bombs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  frame_cnt <= '0;
    else if (vs_sr[0] && !vs_in) frame_cnt <= frame_cnt + FRAME_W'(1);
  end

  // Stage 3 colour lookup, then blanking/clear/off-screen forcing to black.
  always_comb begin
    pix_rgb = COL_BLACK;
    case (ram_rdata)
      EMPTY: pix_rgb = COL_EMPTY;
      WALL:  pix_rgb = (s2_x5 == '0 || s2_x5 == '1 || s2_y5 == '0 || s2_y5 == '1)
                       ? COL_WALL_EDGE : COL_WALL;
      BRICK: pix_rgb = COL_BRICK;
      BOMB:  pix_rgb = frame_cnt[FRAME_W-1] ? COL_BOMB : COL_BLACK;
      default: pix_rgb = COL_BLACK;
    endcase
`ifdef TILE_GRID_EN
    if (s2_x5 == '0 || s2_y5 == '0) pix_rgb = COL_GRID;
`endif
    if (!blank_sr[LATENCY-2] || !s2_vis || !s2_run) pix_rgb = COL_BLACK;
  end

  // Output colour registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= pix_rgb.r;
      vga_g <= pix_rgb.g;
      vga_b <= pix_rgb.b;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: expected pixels are queued when driven
// and compared when they leave the 3-stage pipeline.
`timescale 1ns/1ps
module tb_tile_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic       hs_in, vs_in, blank_in;
  logic       tile_we;
  logic [4:0] tile_col;
  logic [3:0] tile_row;
  logic [1:0] tile_data;
  logic [9:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank, init_done;

  tile_renderer #(.LATENCY(3)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .tile_we(tile_we), .tile_col(tile_col), .tile_row(tile_row), .tile_data(tile_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [29:0] rgb;
    logic [2:0]  syncs;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int map_m [15][20];
  int frame_m;
  bit vs_prev_m;
  bit run_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void init_model();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        map_m[r][c] = (r == 0 || r == 14 || c == 0 || c == 19 ||
                       (r % 2 == 0 && c % 2 == 0)) ? 1 : 0;
    frame_m   = 0;
    vs_prev_m = 1'b1;
    run_m     = 1'b0;
  endfunction

  function automatic logic [29:0] model_rgb(input int x, input int y, input bit blank);
    int xs, ys;
    if (!run_m || !blank || x >= 640 || y >= 480) return 30'h0;
    xs = x % 32;
    ys = y % 32;
`ifdef TILE_GRID_EN
    if (xs == 0 || ys == 0) return {10'h080, 10'h080, 10'h080};
`endif
    case (map_m[y / 32][x / 32])
      0: return {10'h000, 10'h200, 10'h000};
      1: return (xs == 0 || xs == 31 || ys == 0 || ys == 31) ?
                {10'h0FF, 10'h0FF, 10'h0FF} : {10'h1FF, 10'h1FF, 10'h1FF};
      2: return {10'h2C0, 10'h100, 10'h000};
      default: return (frame_m >= 16) ? {10'h3FF, 10'h000, 10'h000} : 30'h0;
    endcase
  endfunction

  // One pixel cycle, optionally with a tile write; called just after a rising edge.
  task automatic drive(input int x, input int y, input bit hs, input bit vs, input bit blank,
                       input bit we, input int col, input int row, input int data,
                       input bit chk, input string tag);
    exp_t e;
    pix_x = 10'(x); pix_y = 10'(y);
    hs_in = hs; vs_in = vs; blank_in = blank;
    tile_we = we; tile_col = 5'(col); tile_row = 4'(row); tile_data = 2'(data);
    if (we && run_m && col < 20 && row < 15) map_m[row][col] = data;
    if (vs_prev_m && !vs) frame_m = (frame_m + 1) % 32;
    vs_prev_m = vs;
    if (chk) begin
      e.due   = cyc + 3;
      e.rgb   = model_rgb(x, y, blank);
      e.syncs = {hs, vs, blank};
      e.tag   = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    tile_we = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input string tag);
    drive(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, tag);
  endtask

  task automatic wr(input int col, input int row, input int data);
    drive(40, 40, 1'b1, 1'b1, 1'b1, 1'b1, col, row, data, 1'b0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(40, 40, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, "");
  endtask

  // Release reset, check black during clear, and time init_done.
  task automatic release_and_init(input string tag);
    int n;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(40 + 32 * i, 40, i % 2, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, {tag, "_clear_black"});
      n++;
    end
    while (!init_done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd301);
    run_m = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, {2'b00, vga_r, vga_g, vga_b}, 32'h0);
    check({tag, "_syncs"}, {29'd0, vga_hs, vga_vs, vga_blank}, 32'b110);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
  endtask

  // Pops every expectation whose pipeline slot has arrived.
  always @(negedge clk) begin : mon
    exp_t m;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m = sb.pop_front();
      if (m.due != cyc) check({m.tag, "_late"}, m.due, cyc);
      else begin
        check({m.tag, "_rgb"}, {2'b00, vga_r, vga_g, vga_b}, {2'b00, m.rgb});
        check({m.tag, "_syncs"}, {29'd0, vga_hs, vga_vs, vga_blank}, {29'd0, m.syncs});
      end
    end
  end

  initial begin
    reset = 1'b1;
    pix_x = '0; pix_y = '0; hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    tile_we = 1'b0; tile_col = '0; tile_row = '0; tile_data = '0;
    init_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_and_init("boot");

    // Initial map contents and edge colours.
    pix(5, 5, "c0_0_wall");
    pix(40, 40, "c1_1_empty");
    pix(72, 72, "c2_2_wall");
    pix(618, 234, "c19_7_wall");
    pix(0, 0, "c0_0_edge");
    pix(639, 479, "corner_edge");
    pix(64, 40, "grid_probe");
    pix(700, 100, "offscreen_x");
    pix(100, 500, "offscreen_y");

    // Random pixels with random sync/blank patterns.
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 719), $urandom_range(0, 519), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'b0, 0, 0, 0, 1'b1, "rand");
    idle(4);

    // Brick write, then out-of-range column writes that must be ignored.
    wr(3, 1, 2);
    pix(100, 40, "brick_c3r1");
    wr(20, 1, 3);
    pix(10, 72, "col20_ignored");
    wr(31, 0, 2);
    pix(11 * 32 + 10, 40, "col31_ignored");

    // Read-before-write then read-after-write on the same tile.
    pix(234, 40, "collide_old");
    drive(234, 40, 1'b1, 1'b1, 1'b1, 1'b1, 7, 1, 2, 1'b1, "collide_new");
    pix(234, 40, "after_write");

    // Bomb blink over 16-frame periods.
    wr(5, 5, 3);
    idle(3);
    pix(170, 170, "bomb_f0");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        drive(40, 40, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, "");
        drive(40, 40, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, "");
      end
      idle(3);
      pix(170, 170, (k == 0) ? "bomb_f16" : "bomb_f32");
    end

    // Blanking forces black.
    drive(40, 40, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, "blank_low");
    idle(5);

    // Mid-run reset: immediate reset values, then a fresh clear.
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun");
    init_model();
    vs_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_and_init("rerun");
    pix(72, 72, "rerun_wall");
    pix(100, 40, "brick_cleared");
    pix(170, 170, "bomb_cleared");
    idle(5);

    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
